bram_sort_ctrl: RTL and testbench

//  Sequencer that sorts the first len words of a single-port synchronous RAM in place, ascending, unsigned.

---
 rtl/bram_sort_pkg.sv | 24 ++
 rtl/bram_sort_cmp_swap.sv | 59 +++++
 rtl/bram_sort_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_bram_sort_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_sort_pkg.sv
// ---------------------------------------------------------------------------
// bram_sort_pkg
// Shared definitions for the in-place RAM bubble sorter.
//   state_e  : sequencer states
//   RD_LAT   : read latency of the attached RAM, in cycles
//   CMP_CYC  : cycles spent on one compare that does not swap
// ---------------------------------------------------------------------------
package bram_sort_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_B,
      CMP,
      WR_A,
      WR_B,
      ADV,
      FIN
   } state_e;

   localparam int RD_LAT  = 1;
   localparam int CMP_CYC = 5;

endpackage

// File: rtl/bram_sort_cmp_swap.sv
// ---------------------------------------------------------------------------
// bram_sort_cmp_swap
// Holds the two words of the pair being compared and flags when they are out
// of order. Comparison is unsigned over the full word.
//   clk, rst : clock and synchronous active-high reset
//   cap_a    : load rd_data into a (first word of the pair)
//   cap_b    : load rd_data into b (second word of the pair)
//   rd_data  : RAM read data
//   a, b     : captured words
//   b_lt_a   : b < a, i.e. the pair must be swapped
// ---------------------------------------------------------------------------
module bram_sort_cmp_swap
   import bram_sort_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cap_a,
   input  logic                  cap_b,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] a,
   output logic [DATA_WIDTH-1:0] b,
   output logic                  b_lt_a
);

   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;

   // Each word is loaded only on its capture strobe and otherwise held, so
   // the pair stays stable through the compare and both write-back cycles.
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (cap_a) begin
         a_d = rd_data;
      end
      if (cap_b) begin
         b_d = rd_data;
      end
   end

   // Capture registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
      end
   end

   // Strictly-less keeps equal words in place, which makes the sort stable.
   assign a      = a_q;
   assign b      = b_q;
   assign b_lt_a = (b_q < a_q);

endmodule

// File: rtl/bram_sort_ctrl.sv
// ---------------------------------------------------------------------------
// bram_sort_ctrl
// Sorts entries 0..len-1 of an external single-port synchronous RAM in place,
// ascending and unsigned, by bubble sort through the RAM port.
//   clk, rst   : clock and synchronous active-high reset
//   start, len : host request; len is latched when start is accepted in IDLE
//   busy, done : busy while sorting, done pulses for one cycle at the end
//   swaps      : number of swaps made by the last sort, saturating
//   ram_cs/oe/we, ram_addr, ram_din : RAM command, all registered
//   ram_dout   : RAM read data, valid the cycle after a read cycle
// Build option: define SORT_EARLY_EXIT_EN to finish as soon as a whole pass
// completes without a swap. Without it every sort runs len-1 passes; the
// final RAM contents are the same either way.
// ---------------------------------------------------------------------------
module bram_sort_ctrl
   import bram_sort_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH:0]   len,
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH+7:0] swaps,
   output logic                     ram_cs,
   output logic                     ram_oe,
   output logic                     ram_we,
   output logic [ADDRESS_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]    ram_din,
   input  logic [DATA_WIDTH-1:0]    ram_dout
);

   localparam int AW = ADDRESS_WIDTH;
   localparam int CW = AW + 1;
   localparam int SW = AW + 8;
   localparam logic [CW-1:0] MAX_LEN = {1'b1, {AW{1'b0}}};

`ifdef SORT_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   state_e          state_q, state_d;
   logic [CW-1:0]   i_q, i_d;
   logic [CW-1:0]   lim_q, lim_d;
   logic            pass_swapped_q, pass_swapped_d;
   logic            cmp_second_q, cmp_second_d;
   logic [SW-1:0]   swaps_q, swaps_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ram_cs_q, ram_cs_d;
   logic            ram_oe_q, ram_oe_d;
   logic            ram_we_q, ram_we_d;
   logic [AW-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;

   logic [CW-1:0]   len_clamped;
   logic            cap_a, cap_b;
   logic [DATA_WIDTH-1:0] word_a, word_b;
   logic            b_lt_a;

   assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

   // a is taken from the read of address i, b from the read of i+1, each one
   // cycle after its read was issued.
   assign cap_a = (state_q == RD_B);
   assign cap_b = (state_q == CMP) && !cmp_second_q;

   bram_sort_cmp_swap #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_cmp_swap (
      .clk     (clk),
      .rst     (rst),
      .cap_a   (cap_a),
      .cap_b   (cap_b),
      .rd_data (ram_dout),
      .a       (word_a),
      .b       (word_b),
      .b_lt_a  (b_lt_a)
   );

   // Next-state logic. CMP lasts two cycles: the first registers b, the
   // second decides from the registered pair, keeping RAM read data out of
   // the compare path. The RAM command is derived from the state being
   // entered so it is registered and lines up with that state's cycle.
   always_comb begin
      state_d        = state_q;
      i_d            = i_q;
      lim_d          = lim_q;
      pass_swapped_d = pass_swapped_q;
      cmp_second_d   = 1'b0;
      swaps_d        = swaps_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               lim_d          = len_clamped;
               i_d            = '0;
               swaps_d        = '0;
               pass_swapped_d = 1'b0;
               state_d        = (len_clamped < CW'(2)) ? FIN : RD_A;
            end
         end
         RD_A: state_d = RD_B;
         RD_B: state_d = CMP;
         CMP: begin
            if (!cmp_second_q) begin
               cmp_second_d = 1'b1;
            end else begin
               state_d = b_lt_a ? WR_A : ADV;
            end
         end
         WR_A: state_d = WR_B;
         WR_B: begin
            swaps_d        = (&swaps_q) ? swaps_q : swaps_q + SW'(1);
            pass_swapped_d = 1'b1;
            state_d        = ADV;
         end
         ADV: begin
            if (({1'b0, i_q} + (CW+1)'(2)) < {1'b0, lim_q}) begin
               i_d     = i_q + CW'(1);
               state_d = RD_A;
            end else begin
               lim_d = lim_q - CW'(1);
               i_d   = '0;
               if ((EARLY_EXIT && !pass_swapped_q) || (lim_q <= CW'(2))) begin
                  state_d = FIN;
               end else begin
                  pass_swapped_d = 1'b0;
                  state_d        = RD_A;
               end
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d     = (state_d != IDLE) && (state_d != FIN);
      done_d     = (state_d == FIN);
      ram_cs_d   = 1'b0;
      ram_oe_d   = 1'b0;
      ram_we_d   = 1'b0;
      ram_addr_d = '0;
      ram_din_d  = '0;

      case (state_d)
         RD_A: begin
            ram_cs_d   = 1'b1;
            ram_oe_d   = 1'b1;
            ram_addr_d = i_d[AW-1:0];
         end
         RD_B: begin
            ram_cs_d   = 1'b1;
            ram_oe_d   = 1'b1;
            ram_addr_d = i_d[AW-1:0] + AW'(1);
         end
         WR_A: begin
            ram_cs_d   = 1'b1;
            ram_we_d   = 1'b1;
            ram_addr_d = i_d[AW-1:0];
            ram_din_d  = word_b;
         end
         WR_B: begin
            ram_cs_d   = 1'b1;
            ram_we_d   = 1'b1;
            ram_addr_d = i_d[AW-1:0] + AW'(1);
            ram_din_d  = word_a;
         end
         default: begin
         end
      endcase
   end

   // State and registered outputs. Reset drops the RAM command immediately,
   // abandoning any sort in progress without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         i_q            <= '0;
         lim_q          <= '0;
         pass_swapped_q <= 1'b0;
         cmp_second_q   <= 1'b0;
         swaps_q        <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         ram_cs_q       <= 1'b0;
         ram_oe_q       <= 1'b0;
         ram_we_q       <= 1'b0;
         ram_addr_q     <= '0;
         ram_din_q      <= '0;
      end else begin
         state_q        <= state_d;
         i_q            <= i_d;
         lim_q          <= lim_d;
         pass_swapped_q <= pass_swapped_d;
         cmp_second_q   <= cmp_second_d;
         swaps_q        <= swaps_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         ram_cs_q       <= ram_cs_d;
         ram_oe_q       <= ram_oe_d;
         ram_we_q       <= ram_we_d;
         ram_addr_q     <= ram_addr_d;
         ram_din_q      <= ram_din_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign swaps    = swaps_q;
   assign ram_cs   = ram_cs_q;
   assign ram_oe   = ram_oe_q;
   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_bram_sort_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bram_sort_ctrl
// Drives bram_sort_ctrl (DW=8, AW=4) against a 1-cycle-latency RAM model and
// compares results with a reference computed from the contents at start:
// sorted order, inversion count as swap count, and done latency derived from
// the number of compares and swaps. Honours SORT_EARLY_EXIT_EN.
// ---------------------------------------------------------------------------
module tb_bram_sort_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

`ifdef SORT_EARLY_EXIT_EN
   localparam bit earlyExit = 1'b1;
`else
   localparam bit earlyExit = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic [AW+7:0] swaps;
   logic          ram_cs;
   logic          ram_oe;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] stim [DEPTH];
   logic          hostWe;
   logic [AW-1:0] hostAddr;
   logic [DW-1:0] hostDin;

   int vectors     = 0;
   int miscompares = 0;
   int protoErrors = 0;
   int writeCount  = 0;
   int doneCount   = 0;

   always #5 clk = ~clk;

   bram_sort_ctrl #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .swaps    (swaps),
      .ram_cs   (ram_cs),
      .ram_oe   (ram_oe),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   // Single-port RAM with one cycle of read latency; the host port is only
   // used to preload contents while the sorter is idle.
   always @(posedge clk) begin
      if (hostWe) begin
         mem[hostAddr] <= hostDin;
      end else if (ram_cs && ram_we) begin
         mem[ram_addr] <= ram_din;
      end
      if (ram_cs && ram_oe) begin
         ram_dout <= mem[ram_addr];
      end
   end

   // Port protocol watcher plus write and done counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (ram_we && ram_oe) protoErrors++;
      if ((ram_we || ram_oe) && !ram_cs) protoErrors++;
      if (ram_cs && ram_we) writeCount++;
      if (done) doneCount++;
   end

   // Counts one comparison and reports it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Copies stim[] into the RAM through the host port.
   task automatic loadRam();
      for (int k = 0; k < DEPTH; k++) begin
         hostWe   = 1'b1;
         hostAddr = AW'(k);
         hostDin  = stim[k];
         @(posedge clk);
         #1;
      end
      hostWe = 1'b0;
   endtask

   // Starts a sort of whatever the RAM holds now and checks the outcome.
   // pulseAt >= 0 raises start again that many cycles into the sort.
   task automatic applyStimulus(input string tag, input int lenIn, input int pulseAt);
      logic [DW-1:0] v    [DEPTH];
      logic [DW-1:0] expv [DEPTH];
      logic [DW-1:0] t;
      int n, inv, maxLeft, left, passes, comps, expLat, cnt, w0, d0;

      n = (lenIn > DEPTH) ? DEPTH : lenIn;
      for (int k = 0; k < DEPTH; k++) begin
         v[k]    = mem[k];
         expv[k] = mem[k];
      end
      for (int a = 0; a < n; a++) begin
         for (int b = a + 1; b < n; b++) begin
            if (expv[b] < expv[a]) begin
               t       = expv[a];
               expv[a] = expv[b];
               expv[b] = t;
            end
         end
      end
      inv     = 0;
      maxLeft = 0;
      for (int k = 0; k < n; k++) begin
         left = 0;
         for (int j = 0; j < k; j++) begin
            if (v[j] > v[k]) left++;
         end
         inv += left;
         if (left > maxLeft) maxLeft = left;
      end
      if (n < 2) begin
         expLat = 0;
      end else begin
         passes = n - 1;
         if (earlyExit && (maxLeft + 1 < passes)) passes = maxLeft + 1;
         comps = 0;
         for (int p = 1; p <= passes; p++) comps += n - p;
         expLat = 5 * comps + 2 * inv;
      end

      w0    = writeCount;
      d0    = doneCount;
      start = 1'b1;
      len   = (AW+1)'(lenIn);
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput({tag, ":busyAfterStart"}, busy, (n >= 2) ? 1 : 0);

      cnt = 0;
      while ((done !== 1'b1) && (cnt < 4000)) begin
         if (cnt == pulseAt) begin
            start = 1'b1;
            len   = (AW+1)'(2);
         end else begin
            start = 1'b0;
            len   = (AW+1)'(lenIn);
         end
         @(posedge clk);
         #1;
         cnt++;
      end
      start = 1'b0;
      len   = (AW+1)'(lenIn);
      checkOutput({tag, ":latency"}, cnt, expLat);
      checkOutput({tag, ":swaps"}, swaps, inv);

      @(posedge clk);
      #1;
      checkOutput({tag, ":doneLowAfter"}, done, 0);
      checkOutput({tag, ":busyLowAfter"}, busy, 0);
      checkOutput({tag, ":donePulses"}, doneCount - d0, 1);
      checkOutput({tag, ":writeCycles"}, writeCount - w0, 2 * inv);
      for (int k = 0; k < DEPTH; k++) begin
         checkOutput($sformatf("%s:ram[%0d]", tag, k), mem[k], expv[k]);
      end
   endtask

   initial begin
      int d0;
      int n;

      rst      = 1'b1;
      start    = 1'b0;
      len      = '0;
      hostWe   = 1'b0;
      hostAddr = '0;
      hostDin  = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset:busy", busy, 0);
      checkOutput("reset:done", done, 0);
      checkOutput("reset:swaps", swaps, 0);
      checkOutput("reset:ram_cs", ram_cs, 0);
      checkOutput("reset:ram_oe", ram_oe, 0);
      checkOutput("reset:ram_we", ram_we, 0);
      checkOutput("reset:ram_addr", ram_addr, 0);
      checkOutput("reset:ram_din", ram_din, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int k = 0; k < DEPTH; k++) stim[k] = DW'(200 + k);
      stim[0] = 9; stim[1] = 3; stim[2] = 7; stim[3] = 1;
      loadRam();
      applyStimulus("sort4", 4, -1);

      applyStimulus("len0", 0, -1);
      applyStimulus("len1", 1, -1);

      stim[0] = 1; stim[1] = 2; stim[2] = 3; stim[3] = 4;
      loadRam();
      applyStimulus("sorted4", 4, -1);

      stim[0] = 5; stim[1] = 5; stim[2] = 2; stim[3] = 5;
      loadRam();
      applyStimulus("dups4", 4, -1);

      for (int k = 0; k < DEPTH; k++) stim[k] = DW'(15 - k);
      loadRam();
      applyStimulus("rev16", 16, -1);

      for (int k = 0; k < DEPTH; k++) stim[k] = DW'($urandom_range(0, 255));
      loadRam();
      applyStimulus("clampLen20", 20, -1);

      for (int k = 0; k < DEPTH; k++) stim[k] = DW'($urandom_range(0, 255));
      loadRam();
      applyStimulus("startWhileBusy", 8, 7);

      for (int k = 0; k < DEPTH; k++) stim[k] = DW'(15 - k);
      loadRam();
      d0    = doneCount;
      start = 1'b1;
      len   = (AW+1)'(16);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midReset:busy", busy, 0);
      checkOutput("midReset:done", done, 0);
      checkOutput("midReset:ram_cs", ram_cs, 0);
      checkOutput("midReset:ram_oe", ram_oe, 0);
      checkOutput("midReset:ram_we", ram_we, 0);
      checkOutput("midReset:ram_addr", ram_addr, 0);
      checkOutput("midReset:ram_din", ram_din, 0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("midReset:noDone", doneCount - d0, 0);
      applyStimulus("afterReset", 16, -1);

      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(2, 16);
         for (int k = 0; k < DEPTH; k++) begin
            stim[k] = (r % 2 == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom_range(0, 3));
         end
         loadRam();
         applyStimulus($sformatf("random%0d", r), n, -1);
      end

      checkOutput("portProtocol", protoErrors, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
